jpeg_cone_sched: RTL

//  Round-robin scheduler sharing one instance of the synthesized 8-input, 1-output JPEG logic cone among NUM_REQ requesters.

---
 rtl/jpeg_cone_pkg.sv | 17 +
 rtl/jpeg_cone_sched_if.sv | 24 ++
 rtl/jpeg_cone_rr_arb.sv | 42 ++++
 rtl/jpeg_cone_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jpeg_cone_pkg.sv
// Shared types and constants for the JPEG cone scheduler slice.
package jpeg_cone_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   localparam int unsigned CONE_IN_W = 8;

   // Requester id width; never below one bit so the id bus always exists.
   function automatic int unsigned id_width(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/jpeg_cone_sched_if.sv
// Request/response channel between the JPEG stage controllers and the cone scheduler.
interface jpeg_cone_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IN_W    = jpeg_cone_pkg::CONE_IN_W,
   parameter int unsigned ID_W    = jpeg_cone_pkg::id_width(NUM_REQ)
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*IN_W-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    rsp_data;
   logic [ID_W-1:0]         rsp_id;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/jpeg_cone_rr_arb.sv
// Round-robin grant among NUM_REQ requesters; pointer moves past each granted requester.
module jpeg_cone_rr_arb
   import jpeg_cone_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_vld,
   output logic [ID_W-1:0]    grant_id
);

   logic [ID_W-1:0] rr_ptr;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         logic [ID_W-1:0] idx;
         idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
         if (enable && !grant_vld && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_vld  = 1'b1;
            grant_id   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/jpeg_cone_sched.sv
// Shares one 8-input JPEG logic cone among NUM_REQ requesters; results return in issue order
// through a credit-protected response FIFO so no cone_out sample is ever dropped.
module jpeg_cone_sched
   import jpeg_cone_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IN_W      = CONE_IN_W,
   parameter int unsigned CONE_LAT  = 1,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   jpeg_cone_sched_if.slave bus,
   output logic [IN_W-1:0]  cone_in,
   input  logic             cone_out,
   output logic             idle
);

   localparam int unsigned ID_W    = id_width(NUM_REQ);
   localparam int unsigned PTR_W   = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENT_W   = ID_W + 1;
   localparam int unsigned TAG_IDW = CONE_LAT * ID_W;

   sched_state_e          state;
   logic [CNT_W-1:0]      credits;
   logic [NUM_REQ-1:0]    grant;
   logic                  grant_vld;
   logic [ID_W-1:0]       grant_id;
   logic [IN_W-1:0]       sel_data;
   logic [CONE_LAT-1:0]   tag_vld;
   logic [TAG_IDW-1:0]    tag_id;
   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  drained;
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic [ENT_W-1:0]      fifo_mem [RSP_DEPTH];
   logic [ENT_W-1:0]      head;

   jpeg_cone_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    ((state == RUN) && (credits != '0)),
      .req_valid (bus.req_valid),
      .grant     (grant),
      .grant_vld (grant_vld),
      .grant_id  (grant_id)
   );

   assign bus.req_ready = grant;

   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) sel_data = bus.req_data[k*IN_W +: IN_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cone_in <= '0;
      end else if (grant_vld) begin
         cone_in <= sel_data;
      end
   end

   // Tag pipe runs in lock-step with the external cone retiming; the oldest stage samples cone_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld <= CONE_LAT'({tag_vld, grant_vld});
         tag_id  <= TAG_IDW'({tag_id, grant_id});
      end
   end

   assign push = tag_vld[CONE_LAT-1];

   // Credits cover FIFO slots plus tags in flight; a tag moving into the FIFO leaves them unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CNT_W'(RSP_DEPTH);
      end else begin
         unique case ({grant_vld, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cone_out, tag_id[TAG_IDW-1 -: ID_W]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign head          = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign pop           = !fifo_empty && bus.rsp_ready;
   assign bus.rsp_valid = !fifo_empty;
   assign bus.rsp_data  = !fifo_empty && head[ENT_W-1];
   assign bus.rsp_id    = fifo_empty ? '0 : head[ID_W-1:0];

   assign drained = (tag_vld == '0) && fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idle  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (en) begin
                  state <= RUN;
                  idle  <= 1'b0;
               end
            end
            RUN: begin
               if (!en) state <= DRAIN;
            end
            DRAIN: begin
               if (en) begin
                  state <= RUN;
               end else if (drained) begin
                  state <= IDLE;
                  idle  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               idle  <= 1'b1;
            end
         endcase
      end
   end

endmodule
